fifo_rd_packer: RTL and testbench
=================================

// Module: fifo_rd_packer
// PURPOSE
//  Read-side consumer of the async FIFO, in the read clock domain. Pops D_SIZE-bit entries from the FIFO's first-word-fall-through
//  read port and packs RATIO consecutive entries, little-endian, into one output word. The word goes out on a valid/ready stream.
//  A partial word is flushed on request or after an idle timeout, and byte-keep flags mark the valid lanes.
// PARAMETERS
//  D_SIZE   8   width of one FIFO entry (lane)
//  RATIO    4   lanes per output word (>=2)
//  TIMEOUT  8   idle cycles with a partial word before auto-flush; 0 disables
//  T_SIZE   4   timeout counter width; 2**T_SIZE > TIMEOUT
// PORTS
//  i_r_clk    in   1              read-domain clock (only clock)
//  i_r_rstn   in   1              asynchronous active-low reset
//  i_empty    in   1              FIFO empty flag
//  i_r_data   in   D_SIZE         FIFO head entry, valid while i_empty=0
//  o_r_inc    out  1              FIFO pop; head advances on next i_r_clk edge
//  i_flush    in   1              1-cycle pulse: emit the partial word as soon as possible
//  o_data     out  D_SIZE*RATIO   packed word; lane k = bits [k*D_SIZE +: D_SIZE]
//  o_keep     out  RATIO          lane-valid mask, always contiguous from lane 0
//  o_valid    out  1              output word valid
//  i_ready    in   1              downstream accepts word when o_valid&i_ready
//  o_lanes    out  clog2(RATIO+1) lanes currently held in the accumulator
// BEHAVIOUR
//  Reset (async assert, sync release):
//   o_valid=0, o_data=0, o_keep=0, o_lanes=0, flush_pending=0, idle counter=0.
//  State: accumulator acc[RATIO lanes] with acc_cnt (0..RATIO), plus output register, flush_pending, and idle counter.
//  Definitions:
//   out_free = !o_valid | i_ready.
//   xfer = out_free & ((acc_cnt==RATIO) | (flush_pending & acc_cnt!=0)).
//   o_r_inc = !i_empty & ((acc_cnt<RATIO) | xfer). o_r_inc is combinational and never asserted while i_empty=1.
//  Pop without xfer: acc lane[acc_cnt] <= i_r_data; acc_cnt++.
//  xfer:
//   o_data <= acc, with unused lanes forced to 0; o_keep <= (1<<acc_cnt)-1; o_valid <= 1.
//   If a pop occurs in the same cycle, the popped entry goes to lane 0 and acc_cnt <= 1; otherwise acc_cnt <= 0.
//  Output register: o_valid&i_ready with no xfer -> o_valid <= 0. o_data and o_keep hold until replaced.
//  Throughput: one pop per cycle sustained; one full word every RATIO cycles when i_ready=1.
//  Backpressure: with the output held and acc full, o_r_inc=0 and the FIFO fills. No entry is ever dropped or duplicated.
//  Flush:
//   i_flush, or an idle-counter hit, sets flush_pending.
//   flush_pending clears on xfer, or in the next cycle if acc_cnt==0, so a flush with an empty accumulator emits nothing.
//   If the output stays blocked, pops continue while flush is pending; the flushed word carries whatever lanes are present at xfer (up to a full word).
//  Idle counter:
//   Increments while acc_cnt!=0 & !pop & !flush_pending; clears on pop, on xfer, or when acc_cnt==0.
//   When it reaches TIMEOUT (TIMEOUT!=0), flush_pending is set and the counter clears.
//  i_flush in the same cycle as an xfer of a full word: flush_pending applies to the lanes popped after it.
//  Mid-operation reset: all accumulated lanes and the output word are discarded; o_valid falls immediately.
// STRUCTURE
//  Shared package fifo_pkg:
//   - keep-mask function keep_mask(cnt, RATIO);
//   - lane-count width function clog2;
//   - shared FIFO handshake parameter defaults (D_SIZE).
//  Sub-module fifo_idle_timer (T_SIZE counter, inputs clear/enable, output hit; TIMEOUT=0 -> hit=0).
//  Remaining logic is flat: accumulator, output register, control equations.
// TESTING (D_SIZE=8, RATIO=4, TIMEOUT=8, i_ready=1 unless stated)
//  1 FIFO holds 11,22,33,44 -> 4 pops in 4 cycles; next cycle o_data=32'h44332211, o_keep=4'hF, o_valid=1 for exactly 1 cycle.
//  2 Stream 8 entries 01..08 back-to-back -> words 32'h04030201 then 32'h08070605.
//     o_r_inc high 8 consecutive cycles.
//  3 Backpressure: i_ready=0, push 12 entries -> first word held.
//     Exactly 8 pops total (4 in the output register, 4 in the accumulator), then o_r_inc=0.
//     Release i_ready -> all 3 words arrive in order, none lost.
//  4 Push AA,BB then FIFO empty -> after 8 idle cycles flush.
//     Output o_data=32'h0000BBAA, o_keep=4'h3. Then o_lanes=0 and no further output.
//  5 Push CC, pulse i_flush -> o_data=32'h000000CC, o_keep=4'h1 within 2 cycles.
//     i_flush with acc empty -> no output.
//  6 Assert i_r_rstn=0 with 3 lanes accumulated and o_valid=1.
//     o_valid, o_keep, o_lanes -> 0 asynchronously. After release, new data packs from lane 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read-side blocks: handshake defaults,
// a constant-safe clog2 and the contiguous lane-keep mask helper.
package fifo_pkg;

  localparam int unsigned DefDSize = 8;
  localparam int unsigned DefRatio = 4;
  localparam int unsigned MaxRatio = 32;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r++;
    end
    return r;
  endfunction

  // Lanes [cnt-1:0] set, clipped to ratio; callers slice the low RATIO bits.
  function automatic logic [MaxRatio-1:0] keep_mask(input int unsigned cnt,
                                                    input int unsigned ratio);
    logic [MaxRatio-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MaxRatio; i++) begin
      m[i] = (i < cnt) && (i < ratio);
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_idle_timer.sv
// Idle cycle counter: raises hit once TIMEOUT enabled cycles have elapsed since the
// last clear, then restarts. TIMEOUT=0 disables the timer entirely.
module fifo_idle_timer #(
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned T_SIZE  = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic hit_o
);

  localparam logic [T_SIZE-1:0] Limit = T_SIZE'(TIMEOUT);

  logic [T_SIZE-1:0] cnt_q, cnt_d;

  assign hit_o = (TIMEOUT != 0) && (cnt_q == Limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || hit_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + T_SIZE'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-domain FIFO consumer: packs RATIO first-word-fall-through entries little-endian into
// one output word on a valid/ready stream, with flush-on-request and idle-timeout flush.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int unsigned D_SIZE  = DefDSize,
  parameter int unsigned RATIO   = DefRatio,
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned T_SIZE  = 4
) (
  input  logic                         i_r_clk,
  input  logic                         i_r_rstn,
  input  logic                         i_empty,
  input  logic [D_SIZE-1:0]            i_r_data,
  output logic                         o_r_inc,
  input  logic                         i_flush,
  output logic [D_SIZE*RATIO-1:0]      o_data,
  output logic [RATIO-1:0]             o_keep,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [clog2(RATIO+1)-1:0]    o_lanes
);

  localparam int unsigned CntW  = clog2(RATIO + 1);
  localparam int unsigned WordW = D_SIZE * RATIO;
  localparam logic [CntW-1:0] FullCnt = CntW'(RATIO);

  logic [RATIO-1:0][D_SIZE-1:0] acc_q, acc_d;
  logic [CntW-1:0]              acc_cnt_q, acc_cnt_d;
  logic [WordW-1:0]             data_q, data_d;
  logic [RATIO-1:0]             keep_q, keep_d;
  logic                         valid_q, valid_d;
  logic                         flush_q, flush_d;

  logic                out_free, xfer, pop, acc_nonempty, hit;
  logic [MaxRatio-1:0] keep_full;
  logic [RATIO-1:0]    keep_now;

  assign acc_nonempty = (acc_cnt_q != '0);
  assign out_free     = !valid_q || i_ready;
  assign xfer         = out_free && ((acc_cnt_q == FullCnt) || (flush_q && acc_nonempty));
  assign pop          = !i_empty && ((acc_cnt_q < FullCnt) || xfer);
  assign keep_full    = keep_mask(32'(acc_cnt_q), RATIO);
  assign keep_now     = keep_full[RATIO-1:0];

  assign o_r_inc = pop;
  assign o_data  = data_q;
  assign o_keep  = keep_q;
  assign o_valid = valid_q;
  assign o_lanes = acc_cnt_q;

  fifo_idle_timer #(
    .TIMEOUT (TIMEOUT),
    .T_SIZE  (T_SIZE)
  ) u_idle_timer (
    .clk_i    (i_r_clk),
    .rst_ni   (i_r_rstn),
    .clear_i  (pop || xfer || !acc_nonempty),
    .enable_i (acc_nonempty && !pop && !flush_q),
    .hit_o    (hit)
  );

  // Accumulator: a pop during xfer restarts the word at lane 0.
  always_comb begin
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    if (xfer) begin
      acc_cnt_d = '0;
      if (pop) begin
        acc_d[0]  = i_r_data;
        acc_cnt_d = CntW'(1);
      end
    end else if (pop) begin
      for (int unsigned k = 0; k < RATIO; k++) begin
        if (acc_cnt_q == CntW'(k)) begin
          acc_d[k] = i_r_data;
        end
      end
      acc_cnt_d = acc_cnt_q + CntW'(1);
    end
  end

  // Output register; lanes beyond acc_cnt are zeroed so stale data never leaks.
  always_comb begin
    data_d  = data_q;
    keep_d  = keep_q;
    valid_d = valid_q;
    if (xfer) begin
      for (int unsigned k = 0; k < RATIO; k++) begin
        data_d[k*D_SIZE +: D_SIZE] = keep_now[k] ? acc_q[k] : '0;
      end
      keep_d  = keep_now;
      valid_d = 1'b1;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  // A request arriving with an xfer survives it and applies to the following lanes.
  assign flush_d = i_flush || hit || (flush_q && !xfer && acc_nonempty);

  always_ff @(posedge i_r_clk or negedge i_r_rstn) begin
    if (!i_r_rstn) begin
      acc_q     <= '0;
      acc_cnt_q <= '0;
      data_q    <= '0;
      keep_q    <= '0;
      valid_q   <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      data_q    <= data_d;
      keep_q    <= keep_d;
      valid_q   <= valid_d;
      flush_q   <= flush_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: FIFO queue model on the read port, captured
// output handshakes, a vector table of pack/flush cases and hand-timed corner sequences.
module tb_fifo_rd_packer;

  logic        clk;
  logic        rst_n;
  logic        i_empty;
  logic [7:0]  i_r_data;
  logic        o_r_inc;
  logic        i_flush;
  logic [31:0] o_data;
  logic [3:0]  o_keep;
  logic        o_valid;
  logic        i_ready;
  logic [2:0]  o_lanes;

  logic [7:0]  fq   [$];
  logic [31:0] rx_d [$];
  logic [3:0]  rx_k [$];
  int          pops;
  int          vcyc;
  int          checks;
  int          errors;

  typedef struct {
    int unsigned     n;
    logic [3:0][7:0] ent;
    bit              flush;
    logic [31:0]     exp_data;
    logic [3:0]      exp_keep;
  } vec_t;

  vec_t vecs [5];

  fifo_rd_packer #(
    .D_SIZE  (8),
    .RATIO   (4),
    .TIMEOUT (8),
    .T_SIZE  (4)
  ) dut (
    .i_r_clk  (clk),
    .i_r_rstn (rst_n),
    .i_empty  (i_empty),
    .i_r_data (i_r_data),
    .o_r_inc  (o_r_inc),
    .i_flush  (i_flush),
    .o_data   (o_data),
    .o_keep   (o_keep),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_lanes  (o_lanes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    i_empty  = (fq.size() == 0);
    i_r_data = (fq.size() == 0) ? 8'h00 : fq[0];
  endtask

  task automatic push(input logic [7:0] v);
    fq.push_back(v);
    drive_fifo();
  endtask

  // Inputs settle before the falling edge; pop/handshake are sampled there.
  task automatic cycle();
    bit pop_s;
    @(negedge clk);
    pop_s = o_r_inc;
    if (o_valid) vcyc++;
    if (o_valid && i_ready) begin
      rx_d.push_back(o_data);
      rx_k.push_back(o_keep);
    end
    @(posedge clk);
    #1;
    if (pop_s && fq.size() != 0) begin
      void'(fq.pop_front());
      pops++;
    end
    drive_fifo();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_words(input string name, input int n);
    int b;
    b = 0;
    while (rx_d.size() < n && b < 80) begin
      cycle();
      b++;
    end
    chk({name, "_word_count"}, 64'(rx_d.size()), 64'(n));
  endtask

  task automatic clear_rx();
    rx_d.delete();
    rx_k.delete();
    pops = 0;
    vcyc = 0;
  endtask

  initial begin
    int first;
    checks   = 0;
    errors   = 0;
    pops     = 0;
    vcyc     = 0;
    rst_n    = 1'b0;
    i_flush  = 1'b0;
    i_ready  = 1'b1;
    drive_fifo();

    vecs[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 4'hF};
    vecs[1] = '{2, 32'h0000BBAA, 1'b0, 32'h0000BBAA, 4'h3};
    vecs[2] = '{1, 32'h000000CC, 1'b1, 32'h000000CC, 4'h1};
    vecs[3] = '{3, 32'h00030201, 1'b1, 32'h00030201, 4'h7};
    vecs[4] = '{3, 32'h00DEADBE, 1'b0, 32'h00DEADBE, 4'h7};

    #12;
    chk("reset_valid", 64'(o_valid), 64'd0);
    chk("reset_data", 64'(o_data), 64'd0);
    chk("reset_keep", 64'(o_keep), 64'd0);
    chk("reset_lanes", 64'(o_lanes), 64'd0);
    chk("reset_inc_empty", 64'(o_r_inc), 64'd0);
    rst_n = 1'b1;
    run(2);

    // Table: push n entries, optional flush, expect exactly one word.
    for (int v = 0; v < 5; v++) begin
      clear_rx();
      for (int k = 0; k < int'(vecs[v].n); k++) push(vecs[v].ent[k]);
      run(int'(vecs[v].n));
      chk($sformatf("vec%0d_lanes", v), 64'(o_lanes), 64'(vecs[v].n));
      if (vecs[v].flush) begin
        i_flush = 1'b1;
        cycle();
        i_flush = 1'b0;
      end
      wait_words($sformatf("vec%0d", v), 1);
      if (rx_d.size() > 0) begin
        chk($sformatf("vec%0d_data", v), 64'(rx_d[0]), 64'(vecs[v].exp_data));
        chk($sformatf("vec%0d_keep", v), 64'(rx_k[0]), 64'(vecs[v].exp_keep));
      end
      run(14);
      chk($sformatf("vec%0d_no_extra", v), 64'(rx_d.size()), 64'd1);
      chk($sformatf("vec%0d_lanes_after", v), 64'(o_lanes), 64'd0);
    end

    // Full word timing: pops in cycles 1-4, valid seen only in cycle 6.
    clear_rx();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    first = 0;
    for (int c = 1; c <= 8; c++) begin
      cycle();
      if (c == 4) chk("t1_pops_4cyc", 64'(pops), 64'd4);
      if (first == 0 && rx_d.size() != 0) first = c;
    end
    chk("t1_first_valid_cycle", 64'(first), 64'd6);
    chk("t1_valid_cycles", 64'(vcyc), 64'd1);

    // Back-to-back stream of 8 entries.
    clear_rx();
    for (int k = 1; k <= 8; k++) push(8'(k));
    run(8);
    chk("t2_pops_8cyc", 64'(pops), 64'd8);
    wait_words("t2", 2);
    if (rx_d.size() >= 2) begin
      chk("t2_word0", 64'(rx_d[0]), 64'h04030201);
      chk("t2_word1", 64'(rx_d[1]), 64'h08070605);
    end

    // Backpressure: output and accumulator fill, then pops stop.
    clear_rx();
    i_ready = 1'b0;
    for (int k = 1; k <= 12; k++) push(8'(k));
    run(20);
    chk("t3_pops_held", 64'(pops), 64'd8);
    chk("t3_inc_low", 64'(o_r_inc), 64'd0);
    chk("t3_held_valid", 64'(o_valid), 64'd1);
    chk("t3_held_data", 64'(o_data), 64'h04030201);
    i_ready = 1'b1;
    wait_words("t3", 3);
    if (rx_d.size() >= 3) begin
      chk("t3_word0", 64'(rx_d[0]), 64'h04030201);
      chk("t3_word1", 64'(rx_d[1]), 64'h08070605);
      chk("t3_word2", 64'(rx_d[2]), 64'h0C0B0A09);
    end
    chk("t3_pops_total", 64'(pops), 64'd12);

    // Idle timeout: two lanes, word appears in cycle 13 and not before.
    clear_rx();
    push(8'hAA); push(8'hBB);
    run(12);
    chk("t4_no_early_flush", 64'(rx_d.size()), 64'd0);
    cycle();
    chk("t4_timeout_word", 64'(rx_d.size()), 64'd1);
    if (rx_d.size() != 0) chk("t4_keep", 64'(rx_k[0]), 64'h3);

    // Flush latency, then flush with an empty accumulator.
    clear_rx();
    push(8'hCC);
    cycle();
    i_flush = 1'b1;
    cycle();
    i_flush = 1'b0;
    run(2);
    chk("t5_flush_latency", 64'(rx_d.size()), 64'd1);
    if (rx_d.size() != 0) chk("t5_data", 64'(rx_d[0]), 64'h000000CC);
    clear_rx();
    i_flush = 1'b1;
    cycle();
    i_flush = 1'b0;
    run(12);
    chk("t5_empty_flush_none", 64'(rx_d.size()), 64'd0);

    // Mid-operation async reset.
    clear_rx();
    i_ready = 1'b0;
    for (int k = 0; k < 7; k++) push(8'h50 + 8'(k));
    run(9);
    chk("t6_pre_lanes", 64'(o_lanes), 64'd3);
    chk("t6_pre_valid", 64'(o_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(o_valid), 64'd0);
    chk("t6_rst_keep", 64'(o_keep), 64'd0);
    chk("t6_rst_lanes", 64'(o_lanes), 64'd0);
    #1;
    rst_n = 1'b1;
    i_ready = 1'b1;
    push(8'h99); push(8'h88); push(8'h77); push(8'h66);
    wait_words("t6", 1);
    if (rx_d.size() != 0) begin
      chk("t6_data", 64'(rx_d[0]), 64'h66778899);
      chk("t6_keep", 64'(rx_k[0]), 64'hF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
